// File: rtl/keypad_bcd_capture.sv
// keypad_bcd_capture
//   Scans a 4x4 active-low matrix keypad and debounces presses and releases.
//   Each accepted press is decoded into a 4-bit key code. Decimal keys shift
//   into a 4-digit BCD word for the display path, and '*' clears that word.
//
// Ports
//   clk_i        system clock
//   rst_i        asynchronous active-low reset
//   row_i[3:0]   keypad rows, active-low, asynchronous to clk_i
//   col_o[3:0]   column drive, active-low, exactly one bit low
//   bcd_o[15:0]  BCD digits, [3:0] units .. [15:12] thousands
//   key_code_o   code of the last accepted key
//   key_valid_o  one-cycle pulse per accepted key
//
// State table
//   state    | meaning
//   SCAN     | stepping the column once per tick, looking for any low row
//   DEBOUNCE | column held, counting consecutive ticks with the latched row low
//   HOLD     | press accepted, counting consecutive all-released ticks
module keypad_bcd_capture #(
  parameter int SCAN_PERIOD    = 27000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  row_i,
  output logic [3:0]  col_o,
  output logic [15:0] bcd_o,
  output logic [3:0]  key_code_o,
  output logic        key_valid_o
);

  localparam int TW = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TW-1:0] TICK_RELOAD = TW'(SCAN_PERIOD - 1);
  localparam logic [TW-1:0] TICK_ONE    = TW'(1);
  localparam logic [CW-1:0] CNT_DONE    = CW'(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      row_meta_q;
  logic [3:0]      row_sync_q;
  logic [TW-1:0]   tick_cnt_q;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [1:0]      row_sel_q, row_sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     bcd_q, bcd_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;

  logic            tick;
  logic            row_any;
  logic [1:0]      row_low_idx;
  logic            accept;
  logic [1:0]      accept_row;
  logic [3:0]      accept_code;

  assign tick    = (tick_cnt_q == '0);
  assign row_any = (row_sync_q != 4'b1111);

  // Lowest-numbered low row wins when several keys share the column.
  always_comb begin
    row_low_idx = 2'd0;
    casez (row_sync_q)
      4'b???0: row_low_idx = 2'd0;
      4'b??01: row_low_idx = 2'd1;
      4'b?011: row_low_idx = 2'd2;
      4'b0111: row_low_idx = 2'd3;
      default: row_low_idx = 2'd0;
    endcase
  end

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = 4'd10;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = 4'd11;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = 4'd12;
      4'hC: code = 4'd14;
      4'hD: code = 4'd0;
      4'hE: code = 4'd15;
      default: code = 4'd13;
    endcase
    return code;
  endfunction

  // Synchronizer and scan tick timer
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
      tick_cnt_q <= TICK_RELOAD;
    end else begin
      row_meta_q <= row_i;
      row_sync_q <= row_meta_q;
      tick_cnt_q <= tick ? TICK_RELOAD : (tick_cnt_q - TICK_ONE);
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_SCAN;
      col_idx_q   <= 2'd0;
      row_sel_q   <= 2'd0;
      cnt_q       <= '0;
      bcd_q       <= 16'h0000;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_sel_q   <= row_sel_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  // Next-state logic; everything moves only on a scan tick
  always_comb begin
    logic [CW-1:0] cnt_inc;
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    row_sel_d  = row_sel_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    accept_row = row_sel_q;
    cnt_inc    = '0;
    if (tick) begin
      unique case (state_q)
        ST_SCAN: begin
          if (row_any) begin
            row_sel_d  = row_low_idx;
            accept_row = row_low_idx;
            if (DEBOUNCE_TICKS == 1) begin
              accept  = 1'b1;
              state_d = ST_HOLD;
              cnt_d   = '0;
            end else begin
              state_d = ST_DEBOUNCE;
              cnt_d   = CNT_ONE;
            end
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (!row_sync_q[row_sel_q]) begin
            cnt_inc = cnt_q + CNT_ONE;
            if (cnt_inc == CNT_DONE) begin
              accept  = 1'b1;
              state_d = ST_HOLD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d   = ST_SCAN;
            col_idx_d = col_idx_q + 2'd1;
            cnt_d     = '0;
          end
        end
        ST_HOLD: begin
          // Any low row restarts the release count, so a held key never re-arms.
          cnt_inc = (&row_sync_q) ? (cnt_q + CNT_ONE) : '0;
          if (cnt_inc == CNT_DONE) begin
            state_d   = ST_SCAN;
            col_idx_d = col_idx_q + 2'd1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_SCAN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output logic: column decode and the registered accept side effects
  always_comb begin
    col_o       = ~(4'b0001 << col_idx_q);
    accept_code = key_map(accept_row, col_idx_q);
    key_valid_d = accept;
    key_code_d  = key_code_q;
    bcd_d       = bcd_q;
    if (accept) begin
      key_code_d = accept_code;
      if (accept_code <= 4'd9) begin
        bcd_d = {bcd_q[11:0], accept_code};
      end else if (accept_code == 4'd14) begin
        bcd_d = 16'h0000;
      end
    end
  end

  assign bcd_o       = bcd_q;
  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;

endmodule

// File: tb/tb_keypad_bcd_capture.sv
module tb_keypad_bcd_capture;

  localparam int SP = 4;
  localparam int DT = 3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [3:0]  row_i;
  logic [3:0]  col_o;
  logic [15:0] bcd_o;
  logic [3:0]  key_code_o;
  logic        key_valid_o;

  logic [15:0] key_down = 16'h0000;
  int          n_checks = 0;
  int          n_errors = 0;
  int          pulses   = 0;
  int          model_val = 0;
  int          code_map [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  keypad_bcd_capture #(
    .SCAN_PERIOD    (SP),
    .DEBOUNCE_TICKS (DT)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .row_i       (row_i),
    .col_o       (col_o),
    .bcd_o       (bcd_o),
    .key_code_o  (key_code_o),
    .key_valid_o (key_valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Physical keypad: a pressed key pulls its row low only while its column is driven low.
  always_comb begin
    row_i = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
  end

  always @(negedge clk_i) if (rst_i && key_valid_o) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic void apply_code(input int code);
    if (code <= 9) model_val = (model_val % 1000) * 10 + code;
    else if (code == 14) model_val = 0;
  endfunction

  // Wait for the scan to step onto column c, so the press is seen on the next tick.
  task automatic align_col(input int c);
    logic [3:0] want;
    int n;
    want = ~(4'b0001 << c);
    n = 0;
    while (col_o === want && n < 64) begin @(negedge clk_i); n++; end
    while (col_o !== want && n < 64) begin @(negedge clk_i); n++; end
    if (n >= 64) chk("align_timeout", 32'(col_o), 32'(want));
  endtask

  task automatic press_keys(input logic [15:0] keys, input int c, input int hold_t, input int rel_t);
    align_col(c);
    key_down = keys;
    repeat (hold_t * SP) @(negedge clk_i);
    key_down = 16'h0000;
    repeat (rel_t * SP) @(negedge clk_i);
  endtask

  task automatic do_key(input int idx, input int hold_t, input int rel_t);
    int p0;
    logic [15:0] m;
    p0 = pulses;
    m  = 16'h0001 << idx;
    press_keys(m, idx % 4, hold_t, rel_t);
    apply_code(code_map[idx]);
    chk($sformatf("pulses_k%0d", idx), 32'(pulses - p0), 32'd1);
    chk($sformatf("code_k%0d", idx), 32'(key_code_o), 32'(code_map[idx]));
    chk($sformatf("bcd_k%0d", idx), 32'(bcd_o), 32'(to_bcd(model_val)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n, p0, idx;

    // Reset values
    repeat (3) @(negedge clk_i);
    chk("rst_col", 32'(col_o), 32'hE);
    chk("rst_bcd", 32'(bcd_o), 32'h0);
    chk("rst_code", 32'(key_code_o), 32'h0);
    chk("rst_valid", 32'(key_valid_o), 32'h0);
    rst_i = 1'b1;

    // Long press of '5': column held, single pulse, release timing
    align_col(1);
    key_down = 16'h0020;
    repeat (40) @(negedge clk_i);
    chk("hold_col_a", 32'(col_o), 32'hD);
    chk("hold_pulses_a", 32'(pulses), 32'd1);
    chk("hold_code", 32'(key_code_o), 32'd5);
    repeat (40) @(negedge clk_i);
    chk("hold_col_b", 32'(col_o), 32'hD);
    chk("hold_pulses_b", 32'(pulses), 32'd1);
    key_down = 16'h0000;
    n = 0;
    while (col_o === 4'hD && n < 40) begin @(negedge clk_i); n++; end
    chk("rel_col", 32'(col_o), 32'hB);
    chk("rel_time", 32'(n >= 11 && n <= 14), 32'd1);
    apply_code(5);
    chk("bcd_5", 32'(bcd_o), 32'h0005);

    // Sequence 1..5 wraps the thousands digit out
    p0 = pulses;
    do_key(0, 5, 5);
    do_key(1, 5, 5);
    do_key(2, 5, 5);
    do_key(4, 5, 5);
    do_key(5, 5, 5);
    chk("seq_bcd", 32'(bcd_o), 32'h2345);
    chk("seq_pulses", 32'(pulses - p0), 32'd5);

    // Build 0572, clear with '*', then 'A' leaves the word alone
    do_key(12, 5, 5);
    do_key(5, 5, 5);
    do_key(8, 5, 5);
    do_key(1, 5, 5);
    chk("bcd_0572", 32'(bcd_o), 32'h0572);
    do_key(12, 5, 5);
    chk("star_bcd", 32'(bcd_o), 32'h0000);
    chk("star_code", 32'(key_code_o), 32'd14);
    do_key(3, 5, 5);
    chk("a_code", 32'(key_code_o), 32'd10);

    // Bounce: row low for two ticks only
    do_key(9, 5, 5);
    p0 = pulses;
    align_col(1);
    key_down = 16'h0020;
    repeat (9) @(negedge clk_i);
    key_down = 16'h0000;
    repeat (3) @(negedge clk_i);
    chk("bounce_col", 32'(col_o), 32'hB);
    repeat (40) @(negedge clk_i);
    chk("bounce_pulses", 32'(pulses - p0), 32'd0);
    chk("bounce_bcd", 32'(bcd_o), 32'(to_bcd(model_val)));

    // Two keys on column 0: row 0 has priority
    do_key(12, 5, 5);
    p0 = pulses;
    press_keys(16'h0011, 0, 5, 5);
    apply_code(1);
    chk("dual_pulses", 32'(pulses - p0), 32'd1);
    chk("dual_code", 32'(key_code_o), 32'd1);
    chk("dual_bcd", 32'(bcd_o), 32'h0001);

    // Randomized key traffic against the model
    for (int i = 0; i < 12; i++) begin
      idx = int'($urandom_range(0, 15));
      do_key(idx, 5 + int'($urandom_range(0, 5)), 5 + int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a debounce
    do_key(10, 5, 5);
    p0 = pulses;
    align_col(0);
    key_down = 16'h0001;
    repeat (6) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("arst_col", 32'(col_o), 32'hE);
    chk("arst_bcd", 32'(bcd_o), 32'h0);
    chk("arst_valid", 32'(key_valid_o), 32'h0);
    key_down = 16'h0000;
    model_val = 0;
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (60) @(negedge clk_i);
    chk("arst_pulses", 32'(pulses - p0), 32'd0);
    chk("arst_bcd_after", 32'(bcd_o), 32'h0);
    do_key(13, 5, 5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
